// File: rtl/block_memory_core.sv
// Dual-port block memory on the daisy-chained register bus: 16-bit chunked bus access
// with a fixed 2-cycle pass-through, plus a full-width single-cycle user port.
module block_memory_core #(
  parameter int unsigned  BASE_ADDR = 0,
  parameter int unsigned  WIDTH     = 18,
  parameter int unsigned  DEPTH     = 256,
  localparam int unsigned N_CHUNKS  = (WIDTH + 15) / 16,
  localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr_i,
  input  logic [15:0]       wdata_i,
  input  logic [15:0]       rdata_i,
  input  logic              rw_i,
  input  logic              valid_i,
  output logic [15:0]       addr_o,
  output logic [15:0]       wdata_o,
  output logic [15:0]       rdata_o,
  output logic              rw_o,
  output logic              valid_o,
  input  logic [ADDR_W-1:0] user_addr,
  input  logic [WIDTH-1:0]  user_din,
  input  logic              user_we,
  output logic [WIDTH-1:0]  user_dout
);

  localparam int unsigned SPAN    = DEPTH * N_CHUNKS;
  localparam int unsigned PAD_W   = 16 * N_CHUNKS;
  localparam int unsigned CHUNK_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [15:0] BASE    = BASE_ADDR[15:0];

  logic [15:0]         off;
  logic                in_range;
  logic [ADDR_W-1:0]   bus_word;
  logic [CHUNK_W-1:0]  bus_chunk;
  logic                last_chunk;
  logic                bus_commit;
  logic                user_hit;
  logic [WIDTH-1:0]    commit_word;
  logic [15:0]         staging [N_CHUNKS];

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    s1_mem;
  logic [PAD_W-1:0]    s1_padded;

  logic                s1_valid;
  logic                s1_rw;
  logic                s1_rd_hit;
  logic [CHUNK_W-1:0]  s1_chunk;
  logic [15:0]         s1_addr;
  logic [15:0]         s1_wdata;
  logic [15:0]         s1_rdata;

  // Addresses below BASE wrap to a large offset and so fall out of range.
  assign off        = addr_i - BASE;
  assign in_range   = 32'(off) < SPAN;
  assign bus_word   = ADDR_W'(off / N_CHUNKS);
  assign bus_chunk  = CHUNK_W'(off % N_CHUNKS);
  assign last_chunk = (bus_chunk == CHUNK_W'(N_CHUNKS - 1));
  assign bus_commit = valid_i && rw_i && in_range && last_chunk;
  assign user_hit   = user_we && (user_addr == bus_word);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    commit_word = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (b / 16 == int'(N_CHUNKS) - 1) commit_word[b] = wdata_i[b % 16];
      else                               commit_word[b] = staging[b / 16][b % 16];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_CHUNKS); i++) staging[i] <= '0;
    end else if (valid_i && rw_i && in_range && !last_chunk) begin
      staging[bus_chunk] <= wdata_i;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  // A user write to the same word is applied after the bus commit check, so the user port wins.
  always_ff @(posedge clk) begin
    s1_mem <= mem[bus_word];
    if (bus_commit && !user_hit) mem[bus_word] <= commit_word;
    if (user_we)                 mem[user_addr] <= user_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) user_dout <= '0;
    else        user_dout <= mem[user_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_rw     <= 1'b0;
      s1_rd_hit <= 1'b0;
      s1_chunk  <= '0;
      s1_addr   <= '0;
      s1_wdata  <= '0;
      s1_rdata  <= '0;
    end else begin
      s1_valid  <= valid_i;
      s1_rw     <= rw_i;
      s1_rd_hit <= valid_i && !rw_i && in_range;
      s1_chunk  <= bus_chunk;
      s1_addr   <= addr_i;
      s1_wdata  <= wdata_i;
      s1_rdata  <= rdata_i;
    end
  end

  // Zero-pad the word to whole chunks so bits above WIDTH read back as 0.
  always_comb begin
    s1_padded              = '0;
    s1_padded[WIDTH-1:0]   = s1_mem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      rw_o    <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
    end else begin
      valid_o <= s1_valid;
      rw_o    <= s1_rw;
      addr_o  <= s1_addr;
      wdata_o <= s1_wdata;
      rdata_o <= s1_rd_hit ? s1_padded[16*s1_chunk +: 16] : s1_rdata;
    end
  end

endmodule

// File: tb/tb_block_memory_core.sv
// Scoreboard bench for block_memory_core: two instances (BASE_ADDR 0 and 0x0100) share
// stimulus; a word-level reference model predicts bus and user-port responses.
module tb_block_memory_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr_i, wdata_i, rdata_i;
  logic        rw_i, valid_i;
  logic [7:0]  user_addr;
  logic [17:0] user_din;
  logic        user_we;

  logic        valid_o [2];
  logic        rw_o    [2];
  logic [15:0] addr_o  [2];
  logic [15:0] wdata_o [2];
  logic [15:0] rdata_o [2];
  logic [17:0] user_dout [2];

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  block_memory_core #(.BASE_ADDR(0), .WIDTH(18), .DEPTH(256)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o[0]), .wdata_o(wdata_o[0]), .rdata_o(rdata_o[0]), .rw_o(rw_o[0]),
    .valid_o(valid_o[0]),
    .user_addr(user_addr), .user_din(user_din), .user_we(user_we), .user_dout(user_dout[0])
  );

  block_memory_core #(.BASE_ADDR(16'h0100), .WIDTH(18), .DEPTH(256)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o[1]), .wdata_o(wdata_o[1]), .rdata_o(rdata_o[1]), .rw_o(rw_o[1]),
    .valid_o(valid_o[1]),
    .user_addr(user_addr), .user_din(user_din), .user_we(user_we), .user_dout(user_dout[1])
  );

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rw;
  } bus_exp_t;

  typedef struct {
    int          due;
    logic [17:0] v0;
    logic [17:0] v1;
  } user_exp_t;

  bus_exp_t  bq0[$];
  bus_exp_t  bq1[$];
  user_exp_t uq[$];
  user_exp_t mon_u;

  // Reference model: whole words per instance plus the low-chunk staging register.
  logic [17:0] ref_mem   [2][256];
  logic [15:0] ref_stage [2];

  function automatic logic [15:0] base_of(input int i);
    return (i == 0) ? 16'h0000 : 16'h0100;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Called right after a falling edge: drive inputs, predict the next rising edge, wait.
  task automatic step(input logic v, input logic rw, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rd,
                      input logic [7:0] ua, input logic [17:0] ud, input logic uwe);
    bus_exp_t    e;
    user_exp_t   u;
    logic [15:0] off;
    int          word, chunk;
    valid_i = v; rw_i = rw; addr_i = a; wdata_i = wd; rdata_i = rd;
    user_addr = ua; user_din = ud; user_we = uwe;
    u.due = edge_n + 1;
    u.v0  = ref_mem[0][ua];
    u.v1  = ref_mem[1][ua];
    uq.push_back(u);
    for (int i = 0; i < 2; i++) begin
      off   = a - base_of(i);
      word  = int'(off) / 2;
      chunk = int'(off) % 2;
      e.due = edge_n + 2; e.addr = a; e.wdata = wd; e.rdata = rd; e.rw = rw;
      if (v && int'(off) < 512) begin
        if (!rw)
          e.rdata = (chunk == 0) ? ref_mem[i][word][15:0] : {14'd0, ref_mem[i][word][17:16]};
        else if (chunk == 0)
          ref_stage[i] = wd;
        else if (!(uwe && int'(ua) == word))
          ref_mem[i][word] = {wd[1:0], ref_stage[i]};
      end
      if (v) begin
        if (i == 0) bq0.push_back(e);
        else        bq1.push_back(e);
      end
    end
    if (uwe) begin
      ref_mem[0][ua] = ud;
      ref_mem[1][ua] = ud;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [7:0] ua);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, ua, 18'h0, 1'b0);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] wd);
    step(1'b1, 1'b1, a, wd, 16'h0000, 8'h00, 18'h0, 1'b0);
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] rd);
    step(1'b1, 1'b0, a, 16'h0000, rd, 8'h00, 18'h0, 1'b0);
  endtask

  // Reset spans exactly one rising edge; anything in flight is dropped.
  task automatic do_reset();
    rst_n = 1'b0;
    valid_i = 1'b0; rw_i = 1'b0; user_we = 1'b0;
    bq0.delete(); bq1.delete(); uq.delete();
    ref_stage[0] = 16'h0; ref_stage[1] = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic mon_bus(input int i);
    bus_exp_t e;
    logic     exp_v;
    exp_v = 1'b0;
    if (i == 0) begin
      if (bq0.size() > 0 && bq0[0].due == edge_n) begin exp_v = 1'b1; e = bq0.pop_front(); end
    end else begin
      if (bq1.size() > 0 && bq1[0].due == edge_n) begin exp_v = 1'b1; e = bq1.pop_front(); end
    end
    check($sformatf("valid_o[%0d]", i), 128'(valid_o[i]), 128'(exp_v));
    if (exp_v) begin
      check($sformatf("addr_o[%0d]", i),  128'(addr_o[i]),  128'(e.addr));
      check($sformatf("wdata_o[%0d]", i), 128'(wdata_o[i]), 128'(e.wdata));
      check($sformatf("rw_o[%0d]", i),    128'(rw_o[i]),    128'(e.rw));
      check($sformatf("rdata_o[%0d] addr %0h", i, e.addr), 128'(rdata_o[i]), 128'(e.rdata));
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < 2; i++)
          check($sformatf("reset_outputs[%0d]", i),
                128'({valid_o[i], rw_o[i], addr_o[i], wdata_o[i], rdata_o[i], user_dout[i]}),
                128'(0));
      end else begin
        mon_bus(0);
        mon_bus(1);
        if (uq.size() > 0 && uq[0].due == edge_n) begin
          mon_u = uq.pop_front();
          check("user_dout[0]", 128'(user_dout[0]), 128'(mon_u.v0));
          check("user_dout[1]", 128'(user_dout[1]), 128'(mon_u.v1));
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    valid_i = 1'b0; rw_i = 1'b0; addr_i = '0; wdata_i = '0; rdata_i = '0;
    user_addr = '0; user_din = '0; user_we = 1'b0;
    ref_stage[0] = 16'h0; ref_stage[1] = 16'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Give every word a known value through the user port.
    for (int k = 0; k < 256; k++) step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, k[7:0], 18'($urandom), 1'b1);

    // Chunked write, then user read of word 0.
    bus_wr(16'h0000, 16'h0004);
    bus_wr(16'h0001, 16'h0003);
    idle(8'd0); idle(8'd0);

    // User write, then bus reads of both chunks.
    step(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'd5, 18'h2ABCD, 1'b1);
    bus_rd(16'd10, 16'h1234);
    bus_rd(16'd11, 16'h5678);
    idle(8'd5);

    // Out-of-range pass-through and range edges for the BASE_ADDR=0x0100 instance.
    bus_rd(16'h0050, 16'hBEEF);
    bus_rd(16'h0300, 16'hBEEF);
    bus_rd(16'h02FF, 16'hBEEF);
    bus_rd(16'h0100, 16'hBEEF);
    bus_rd(16'h01FF, 16'hCAFE);
    bus_rd(16'h0200, 16'hCAFE);
    idle(8'd0);

    // Back-to-back: writes then reads on consecutive cycles.
    bus_wr(16'd2, 16'h1111);
    bus_wr(16'd3, 16'h0001);
    bus_rd(16'd2, 16'h0000);
    bus_rd(16'd3, 16'h0000);
    idle(8'd1); idle(8'd1);

    // Collision on word 7: the user write wins.
    bus_wr(16'd14, 16'h0001);
    step(1'b1, 1'b1, 16'd15, 16'h0000, 16'h0000, 8'd7, 18'h3FFFF, 1'b1);
    bus_rd(16'd14, 16'h0000);
    bus_rd(16'd15, 16'h0000);
    idle(8'd7); idle(8'd7);

    // Reset one cycle after a read; staging must be cleared afterwards.
    bus_wr(16'd0, 16'h9999);
    bus_rd(16'd4, 16'h4444);
    do_reset();
    bus_wr(16'd1, 16'h0002);
    bus_rd(16'd0, 16'h0000);
    bus_rd(16'd1, 16'h0000);
    idle(8'd0); idle(8'd0);

    // Randomised traffic, mostly near both decoded ranges.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 9) < 8) ra = 16'($urandom_range(0, 16'h03FF));
        else                          ra = 16'($urandom);
        step($urandom_range(0, 4) != 0, 1'($urandom), ra, 16'($urandom), 16'($urandom),
             8'($urandom), 18'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    repeat (4) idle(8'd0);
    check("drain_bus0", 128'(bq0.size()), 128'(0));
    check("drain_bus1", 128'(bq1.size()), 128'(0));
    check("drain_user", 128'(uq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
